// File: rtl/auto_strummer.sv
// -----------------------------------------------------------------------------
// auto_strummer
// Scripted player for demo / self-test mode. Accepts the prompted note and
// drives the four active-low fret buttons like a human: a reaction delay, a
// hold, a release, and a quiet gap before the next note is taken. A 16-bit
// LFSR turns some presses into deliberate wrong-button presses so the scoring
// penalty path gets exercised.
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_enable      autoplay enable; low aborts any press in progress
//   i_note_valid  one-cycle strobe: new note presented
//   i_note_num    note to hit (0-3), sampled with i_note_valid
//   i_miss_rate   wrong-press probability in sixteenths
//   o_buttons     active-low button drive, bit n = button n (registered)
//   o_busy        high from note acceptance until the gap ends
//   o_presses     presses issued (saturating)
//   o_misses      deliberate wrong presses (saturating)
//   o_dropped     note strobes not accepted (saturating)
// -----------------------------------------------------------------------------
module auto_strummer #(
    parameter int          REACT_CYCLES = 50,
    parameter int          HOLD_CYCLES  = 20,
    parameter int          GAP_CYCLES   = 10,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_note_valid,
    input  logic [3:0] i_note_num,
    input  logic [3:0] i_miss_rate,
    output logic [3:0] o_buttons,
    output logic       o_busy,
    output logic [7:0] o_presses,
    output logic [7:0] o_misses,
    output logic [7:0] o_dropped
);

    localparam int MAX_A   = (REACT_CYCLES > HOLD_CYCLES) ? REACT_CYCLES : HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REACT, S_PRESS, S_GAP} state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [1:0]    r_target, w_target_next;
    logic          r_miss, w_miss_next;
    logic [15:0]   r_lfsr;
    logic [3:0]    r_buttons, w_buttons_next;
    logic [7:0]    r_presses, r_misses, r_dropped;
    logic          w_press_start;
    logic          w_drop;
    logic          w_lfsr_fb;

    // Fibonacci taps 16,14,13,11 (bit indices 15,13,12,10)
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_target_next = r_target;
        w_miss_next   = r_miss;
        w_press_start = 1'b0;
        w_drop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_note_valid) begin
                    if (i_enable && (i_note_num[3:2] == 2'b00)) begin
                        w_state_next = S_REACT;
                        w_cnt_next   = CW'(REACT_CYCLES - 1);
                        if (r_lfsr[3:0] >= i_miss_rate) begin
                            w_target_next = i_note_num[1:0];
                            w_miss_next   = 1'b0;
                        end else begin
                            // 2-bit add wraps 3 -> 0
                            w_target_next = i_note_num[1:0] + 2'd1;
                            w_miss_next   = 1'b1;
                        end
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_REACT: begin
                if (r_cnt == '0) begin
                    w_state_next  = S_PRESS;
                    w_cnt_next    = CW'(HOLD_CYCLES - 1);
                    w_press_start = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_PRESS: begin
                if (r_cnt == '0) begin
                    w_state_next = S_GAP;
                    // The release lands one clock after GAP entry, so the
                    // gap counter runs one extra cycle to keep the buttons
                    // released for the full gap while busy.
                    w_cnt_next   = CW'(GAP_CYCLES);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Strobes arriving while a note is in flight are not queued.
        if (r_state != S_IDLE && i_note_valid) begin
            w_drop = 1'b1;
        end

        // Enable low aborts immediately; nothing new is counted.
        if (r_state != S_IDLE && !i_enable) begin
            w_state_next  = S_IDLE;
            w_cnt_next    = '0;
            w_press_start = 1'b0;
        end
    end

    // Buttons follow the PRESS state one clock later, giving the extra cycle
    // of latency between PRESS entry and the button edge.
    always_comb begin
        w_buttons_next = 4'b1111;
        if (r_state == S_PRESS && i_enable) begin
            w_buttons_next[r_target] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_target  <= 2'd0;
            r_miss    <= 1'b0;
            r_lfsr    <= LFSR_SEED;
            r_buttons <= 4'b1111;
            r_presses <= 8'd0;
            r_misses  <= 8'd0;
            r_dropped <= 8'd0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_target  <= w_target_next;
            r_miss    <= w_miss_next;
            r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
            r_buttons <= w_buttons_next;
            if (w_press_start && r_presses != 8'hFF) begin
                r_presses <= r_presses + 8'd1;
            end
            if (w_press_start && r_miss && r_misses != 8'hFF) begin
                r_misses <= r_misses + 8'd1;
            end
            if (w_drop && r_dropped != 8'hFF) begin
                r_dropped <= r_dropped + 8'd1;
            end
        end
    end

    assign o_buttons = r_buttons;
    assign o_busy    = (r_state != S_IDLE);
    assign o_presses = r_presses;
    assign o_misses  = r_misses;
    assign o_dropped = r_dropped;

endmodule

// File: tb/tb_auto_strummer.sv
// -----------------------------------------------------------------------------
// tb_auto_strummer
// Self-checking bench for auto_strummer. Expected press targets go into a
// queue when a note is strobed and are popped when a button falls.
// -----------------------------------------------------------------------------
module tb_auto_strummer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       note_valid;
    logic [3:0] note_num;
    logic [3:0] miss_rate;
    logic [3:0] buttons;
    logic       busy;
    logic [7:0] presses;
    logic [7:0] misses;
    logic [7:0] dropped;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    int         exp_presses = 0;
    int         exp_misses  = 0;
    int         exp_dropped = 0;
    int         n_btn0      = 0;
    logic [15:0] m_lfsr;
    logic [3:0]  prev_buttons;

    auto_strummer #(
        .REACT_CYCLES(50),
        .HOLD_CYCLES (20),
        .GAP_CYCLES  (10),
        .LFSR_SEED   (SEED)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_note_valid(note_valid),
        .i_note_num  (note_num),
        .i_miss_rate (miss_rate),
        .o_buttons   (buttons),
        .o_busy      (busy),
        .o_presses   (presses),
        .o_misses    (misses),
        .o_dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, stepping every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // Press monitor: on every falling button, pop and compare the target.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_buttons = 4'b1111;
        end else begin
            if ($countones(~buttons) > 1) begin
                checks++;
                failures++;
                $display("FAIL one_button_low: buttons=%b required at most one low", buttons);
            end
            if (buttons != 4'b1111 && prev_buttons == 4'b1111) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_press: buttons=%b required no press", buttons);
                end else begin
                    logic [1:0] t;
                    logic [3:0] want;
                    t = exp_q.pop_front();
                    want = 4'b1111;
                    want[t] = 1'b0;
                    if (buttons !== want) begin
                        failures++;
                        $display("FAIL press_target: buttons=%b required %b", buttons, want);
                    end else begin
                        $display("press ok: buttons=%b", buttons);
                    end
                    if (buttons[0] == 1'b0) n_btn0++;
                end
            end
            prev_buttons = buttons;
        end
    end

    task automatic apply_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        note_valid = 1'b0;
        note_num   = 4'd0;
        miss_rate  = 4'd0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_presses = 0;
        exp_misses  = 0;
        exp_dropped = 0;
        n_btn0      = 0;
        rst_n  = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
    endtask

    // Strobe a note that must be accepted; expectation derived from the model LFSR.
    task automatic send_note(input logic [3:0] num);
        logic miss;
        miss = (m_lfsr[3:0] < miss_rate);
        exp_q.push_back(miss ? (num[1:0] + 2'd1) : num[1:0]);
        if (exp_presses < 255) exp_presses++;
        if (miss && exp_misses < 255) exp_misses++;
        note_valid = 1'b1;
        note_num   = num;
        @(negedge clk);
        note_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL wait_idle_timeout: busy=%b required 0 within 500 cycles", busy);
        end
    endtask

    // Runs one note with cycle-exact checks; optionally strobes extra notes
    // in REACT, PRESS and GAP, which must all be dropped.
    task automatic run_timed(input logic [3:0] num, input bit extra);
        logic [3:0] want_btn;
        logic       want_busy;
        send_note(num);           // now just after the acceptance edge E0
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            note_valid = 1'b0;
            want_btn = 4'b1111;
            if (k >= 51 && k <= 70) want_btn[num[1:0]] = 1'b0;
            want_busy = (k <= 80);
            checks++;
            if (buttons !== want_btn || busy !== want_busy) begin
                failures++;
                $display("FAIL timing_k%0d: buttons=%b busy=%b required %b %b",
                         k, buttons, busy, want_btn, want_busy);
            end
            if (extra && (k == 10 || k == 60 || k == 75)) begin
                note_valid = 1'b1;
                note_num   = 4'd1;
                exp_dropped++;
            end
        end
        note_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; note_valid = 1'b0; note_num = 4'd0; miss_rate = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (buttons !== 4'b1111 || busy !== 1'b0 || presses !== 8'd0 ||
            misses !== 8'd0 || dropped !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: buttons=%b busy=%b p=%0d m=%0d d=%0d required 1111 0 0 0 0",
                     buttons, busy, presses, misses, dropped);
        end else $display("reset ok");
    endtask

    task automatic test_single_note();
        apply_reset();
        run_timed(4'd2, 1'b0);
        checks++;
        if (presses !== 8'd1 || misses !== 8'd0 || dropped !== 8'd0) begin
            failures++;
            $display("FAIL single_counts: p=%0d m=%0d d=%0d required 1 0 0", presses, misses, dropped);
        end else $display("single note ok");
    endtask

    task automatic test_miss_rate();
        apply_reset();
        miss_rate = 4'd15;
        for (int i = 0; i < 64; i++) begin
            send_note(4'd3);
            wait_idle();
        end
        @(negedge clk);
        checks++;
        if (presses !== 8'(exp_presses) || misses !== 8'(exp_misses)) begin
            failures++;
            $display("FAIL miss_counts: p=%0d m=%0d required %0d %0d",
                     presses, misses, exp_presses, exp_misses);
        end else $display("miss run ok: p=%0d m=%0d", presses, misses);
        checks++;
        if (int'(misses) != n_btn0 || presses !== 8'd64) begin
            failures++;
            $display("FAIL miss_vs_btn0: misses=%0d btn0=%0d presses=%0d required equal and 64",
                     misses, n_btn0, presses);
        end
    endtask

    task automatic test_busy_drop();
        apply_reset();
        run_timed(4'd0, 1'b1);
        checks++;
        if (dropped !== 8'(exp_dropped) || presses !== 8'd1) begin
            failures++;
            $display("FAIL busy_drop: d=%0d p=%0d required %0d 1", dropped, presses, exp_dropped);
        end else $display("busy drop ok: d=%0d", dropped);
    endtask

    task automatic test_invalid();
        apply_reset();
        note_valid = 1'b1; note_num = 4'd5;
        @(negedge clk);
        exp_dropped++;
        enable = 1'b0; note_num = 4'd1;
        @(negedge clk);
        exp_dropped++;
        note_valid = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (buttons !== 4'b1111 || busy !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL invalid_idle: buttons=%b busy=%b required 1111 0", buttons, busy);
            end
        end
        checks++;
        if (dropped !== 8'(exp_dropped) || presses !== 8'd0) begin
            failures++;
            $display("FAIL invalid_dropped: d=%0d p=%0d required %0d 0", dropped, presses, exp_dropped);
        end else $display("invalid notes ok: d=%0d", dropped);
    endtask

    task automatic test_enable_abort();
        apply_reset();
        send_note(4'd1);
        repeat (60) @(negedge clk);
        checks++;
        if (buttons !== 4'b1101) begin
            failures++;
            $display("FAIL abort_pre: buttons=%b required 1101", buttons);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (buttons !== 4'b1111 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_release: buttons=%b busy=%b required 1111 0", buttons, busy);
        end else $display("abort ok");
        enable = 1'b1;
        @(negedge clk);
        run_timed(4'd3, 1'b0);
        checks++;
        if (presses !== 8'd2) begin
            failures++;
            $display("FAIL abort_presses: p=%0d required 2", presses);
        end
    endtask

    task automatic test_saturation_and_reset();
        int n;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            send_note(4'(i % 4));
            wait_idle();
        end
        @(negedge clk);
        checks++;
        if (presses !== 8'd255 || misses !== 8'd0 || dropped !== 8'd0) begin
            failures++;
            $display("FAIL saturation: p=%0d m=%0d d=%0d required 255 0 0", presses, misses, dropped);
        end else $display("saturation ok");
        send_note(4'd2);
        n = 0;
        while (buttons == 4'b1111 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (buttons !== 4'b1011) begin
            failures++;
            $display("FAIL sat_press: buttons=%b required 1011", buttons);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (buttons !== 4'b1111 || busy !== 1'b0 || presses !== 8'd0 ||
            misses !== 8'd0 || dropped !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: buttons=%b busy=%b p=%0d m=%0d d=%0d required 1111 0 0 0 0",
                     buttons, busy, presses, misses, dropped);
        end else $display("async reset ok");
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_miss_rate();
        test_busy_drop();
        test_invalid();
        test_enable_abort();
        test_saturation_and_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_presses: queue=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/auto_strummer.md
Name: auto_strummer

Overview:
- Scripted player for demo and self-test mode: the responder side of the note/button interface.
- Takes the note currently prompted to the player and drives the four active-low fret buttons the way a human would: reaction delay, hold, release.
- Sits between the note generator's hit-number output and the game core's button inputs, muxed in place of the physical buttons.
- A 16-bit LFSR injects wrong-button presses at a programmable rate so the scoring penalty path gets exercised.

Parameters:
REACT_CYCLES, 50, cycles from note acceptance to button assertion (>=1)
HOLD_CYCLES, 20, cycles the chosen button is held low (>=1)
GAP_CYCLES, 10, cycles all buttons stay released before a new note is accepted (>=1)
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
enable  input  1  autoplay enable; low aborts any press in progress
note_valid  input  1  one-cycle strobe: new note presented
note_num  input  4  note to hit, valid codes 0-3, sampled with note_valid
miss_rate  input  4  wrong-press probability in sixteenths (0 = never, 15 = 15/16)
buttons  output  4  active-low button drive, bit n = button n
busy  output  1  high from note acceptance until the gap ends
presses  output  8  count of presses issued, saturating
misses  output  8  count of deliberate wrong presses, saturating
dropped  output  8  count of note_valid strobes not accepted, saturating

Behaviour:
- Reset (rst low, asynchronous):
  - buttons = 4'b1111, busy = 0, presses = misses = dropped = 0.
  - State = IDLE, LFSR = LFSR_SEED, internal counters = 0.
- LFSR:
  - 16-bit Fibonacci, taps 16, 14, 13, 11; shifts every clock regardless of state.
  - Its low nibble is sampled on the acceptance cycle.
- States: IDLE, REACT, PRESS, GAP.
- IDLE:
  - Accept when note_valid = 1, enable = 1 and note_num <= 3.
  - On acceptance, latch the target: note_num if lfsr[3:0] >= miss_rate, otherwise (note_num + 1) mod 4 with a miss flag set.
  - Load the counter with REACT_CYCLES - 1, go to REACT, busy = 1 next cycle.
  - note_valid with note_num > 3, or with enable = 0: dropped += 1, stay in IDLE.
- REACT:
  - Counter decrements each cycle.
  - Leaving at count 0: go to PRESS, drive buttons[target] = 0 from the next cycle.
  - presses += 1 and, if miss flag set, misses += 1, both on entry to PRESS.
  - Net latency: button falls exactly REACT_CYCLES + 1 clocks after the note_valid edge.
- PRESS:
  - Hold for exactly HOLD_CYCLES cycles.
  - Then buttons = 4'b1111 and go to GAP.
- GAP:
  - All buttons released for GAP_CYCLES cycles.
  - Then go to IDLE with busy = 0 on that same transition.
- Only one button is ever low at a time. buttons is registered, so there are no glitches.
- note_valid while busy = 1: ignored for the press, dropped += 1. No queueing.
- enable falling in REACT/PRESS/GAP:
  - Next cycle: state = IDLE, buttons = 4'b1111, busy = 0.
  - Press counters keep their values; a press already counted is not undone.
- Counters saturate at 255 and never wrap.
- miss_rate = 0 never misses. miss_rate is sampled only on acceptance; changes mid-note have no effect.
- Reset mid-press releases all buttons immediately (asynchronously).

Test Plan:
- Reset release, enable = 1, note_valid with note_num = 2, miss_rate = 0:
  - buttons = 4'b1011 starting 51 clocks after the strobe, for 20 clocks, then 1111.
  - busy drops 10 clocks after release; presses = 1, misses = 0.
- miss_rate = 15, 64 back-to-back notes (each strobe issued after busy falls), note_num = 3:
  - every press is either button 3 or button 0;
  - misses equals the count of button-0 presses (model-checked against an LFSR reference);
  - presses = 64.
- note_valid strobed in REACT, in PRESS and in GAP of one note:
  - no extra press; dropped = 3; first note timing unchanged.
- note_num = 5 and, separately, note_valid with enable = 0:
  - buttons stay 1111, busy stays 0, dropped = 2.
- enable deasserted 10 clocks into PRESS:
  - buttons = 1111 and busy = 0 on the next clock;
  - a following valid note is accepted normally.
- 300 accepted notes with miss_rate = 0:
  - presses saturates at 255, misses = 0;
  - rst pulse low mid-press: buttons = 1111 immediately, all counters 0.
